// File: rtl/freelist_ckpt.sv
// rtl/freelist_ckpt.sv - multi-port tag free list with circular branch checkpoints
// Optional protocol checker enabled by defining FREELIST_CHK_EN.
module freelist_ckpt #(
  parameter int DEPTH = 32,
  parameter int READ  = 4,
  parameter int WRITE = 4,
  parameter int CKPT  = 4,
  localparam int DATA = $clog2(DEPTH),
  localparam int CID  = $clog2(CKPT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_,
  input  logic [READ-1:0]       re_,
  output logic [READ*DATA-1:0]  rd,
  output logic [READ-1:0]       v,
  input  logic [WRITE-1:0]      we_,
  input  logic [WRITE*DATA-1:0] wd,
  input  logic                  ckpt_,
  output logic [CID-1:0]        ckpt_id,
  output logic                  ckpt_full,
  input  logic                  cmt_,
  input  logic                  rstr_,
  input  logic [CID-1:0]        rstr_id,
  output logic                  busy,
  output logic                  err
);

  localparam logic [CID:0] FULL = (CID+1)'(CKPT);

  logic [DEPTH-1:0] usage;
  logic [DEPTH-1:0] snap [CKPT];
  logic [CID-1:0]   head, tail;
  logic [CID:0]     count;
  logic             busy_q;

  logic [DATA-1:0]  rd_a [READ];
  logic [DATA-1:0]  wd_a [WRITE];
  logic [DEPTH-1:0] allocs, rels, next_usage, usage_n;
  logic [CID-1:0]   rstr_off;
  logic             live, restore_ok, do_ckpt, do_cmt, busy_n;
  int               pc;

  // Port i gets the (i+1)-th lowest free tag, regardless of other ports' requests.
  always_comb begin
    int cnt;
    for (int i = 0; i < READ; i++) begin
      rd_a[i] = '0;
      v[i]    = 1'b0;
      cnt     = 0;
      for (int k = 0; k < DEPTH; k++) begin
        if (!usage[k]) begin
          if (cnt == i) begin
            rd_a[i] = DATA'(k);
            v[i]    = 1'b1;
          end
          cnt = cnt + 1;
        end
      end
    end
  end

  for (genvar g = 0; g < READ; g++) begin : g_rd
    assign rd[g*DATA +: DATA] = rd_a[g];
  end

  for (genvar g = 0; g < WRITE; g++) begin : g_wd
    assign wd_a[g] = wd[g*DATA +: DATA];
  end

  always_comb begin
    allocs = '0;
    rels   = '0;
    for (int i = 0; i < READ; i++)
      if (!re_[i] && v[i]) allocs[rd_a[i]] = 1'b1;
    for (int j = 0; j < WRITE; j++)
      if (!we_[j]) rels[wd_a[j]] = 1'b1;
  end

  assign next_usage = (usage | allocs) & ~rels;
  assign rstr_off   = rstr_id - head;
  assign live       = ({1'b0, rstr_off} < count);
  assign restore_ok = !rstr_ && live;
  assign do_ckpt    = !ckpt_ && !restore_ok && (count != FULL);
  assign do_cmt     = !cmt_ && !restore_ok && (count != '0);
  assign usage_n    = restore_ok ? (snap[rstr_id] & ~rels) : next_usage;

  always_comb begin
    pc = 0;
    for (int k = 0; k < DEPTH; k++)
      if (!usage_n[k]) pc = pc + 1;
  end
  assign busy_n = (pc < READ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      usage  <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      busy_q <= 1'b0;
      for (int s = 0; s < CKPT; s++) snap[s] <= '0;
    end else if (!flush_) begin
      usage  <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      busy_q <= 1'b0;
      for (int s = 0; s < CKPT; s++) snap[s] <= '0;
    end else begin
      usage  <= usage_n;
      busy_q <= busy_n;
      // Released tags must also vanish from every snapshot so a restore cannot resurrect them.
      for (int s = 0; s < CKPT; s++) begin
        if (do_ckpt && (CID'(s) == tail)) snap[s] <= next_usage;
        else                              snap[s] <= snap[s] & ~rels;
      end
      if (restore_ok) begin
        tail  <= rstr_id;
        count <= {1'b0, rstr_off};
      end else begin
        if (do_ckpt) tail <= tail + 1'b1;
        if (do_cmt)  head <= head + 1'b1;
        if (do_ckpt && !do_cmt)      count <= count + 1'b1;
        else if (!do_ckpt && do_cmt) count <= count - 1'b1;
      end
    end
  end

  assign busy      = busy_q;
  assign ckpt_full = (count == FULL);
  assign ckpt_id   = tail;

`ifdef FREELIST_CHK_EN
  logic err_q, err_n;

  always_comb begin
    err_n = 1'b0;
    for (int j = 0; j < WRITE; j++) begin
      if (!we_[j] && !usage[wd_a[j]]) err_n = 1'b1;
      for (int k = j + 1; k < WRITE; k++)
        if (!we_[j] && !we_[k] && (wd_a[j] == wd_a[k])) err_n = 1'b1;
    end
    if (!ckpt_ && !restore_ok && (count == FULL)) err_n = 1'b1;
    if (!cmt_ && !restore_ok && (count == '0))    err_n = 1'b1;
    if (!rstr_ && !live)                          err_n = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err_q <= 1'b0;
    else if (!flush_) err_q <= 1'b0;
    else if (err_n)   err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_freelist_ckpt.sv
// tb/tb_freelist_ckpt.sv - directed self-checking bench for freelist_ckpt
module tb_freelist_ckpt;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush_ = 1'b1;
  logic [1:0] re_ = 2'b11;
  logic [5:0] rd;
  logic [1:0] v;
  logic [1:0] we_ = 2'b11;
  logic [5:0] wd = '0;
  logic       ckpt_ = 1'b1;
  logic [0:0] ckpt_id;
  logic       ckpt_full;
  logic       cmt_ = 1'b1;
  logic       rstr_ = 1'b1;
  logic [0:0] rstr_id = '0;
  logic       busy;
  logic       err;

  int checks = 0;
  int failures = 0;

`ifdef FREELIST_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  freelist_ckpt #(.DEPTH(8), .READ(2), .WRITE(2), .CKPT(2)) dut (
    .clk(clk), .reset(reset), .flush_(flush_), .re_(re_), .rd(rd), .v(v),
    .we_(we_), .wd(wd), .ckpt_(ckpt_), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .cmt_(cmt_), .rstr_(rstr_), .rstr_id(rstr_id), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    flush_ = 1'b1; re_ = 2'b11; we_ = 2'b11; wd = '0;
    ckpt_ = 1'b1; cmt_ = 1'b1; rstr_ = 1'b1; rstr_id = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (v !== 2'b11) begin failures++; $display("FAIL reset_v actual=%b expected=%b", v, 2'b11); end
    checks++; if (rd !== {3'd1, 3'd0}) begin failures++; $display("FAIL reset_rd actual=%h expected=%h", rd, {3'd1, 3'd0}); end
    checks++; if (ckpt_id !== 1'b0) begin failures++; $display("FAIL reset_ckpt_id actual=%b expected=0", ckpt_id); end
    checks++; if (ckpt_full !== 1'b0) begin failures++; $display("FAIL reset_full actual=%b expected=0", ckpt_full); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b expected=0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err actual=%b expected=0", err); end
  endtask

  task automatic test_alloc();
    logic [5:0] exp_rd [3];
    exp_rd[0] = {3'd3, 3'd2};
    exp_rd[1] = {3'd5, 3'd4};
    exp_rd[2] = {3'd7, 3'd6};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      re_ = 2'b00;
      step();
      checks++; if (rd !== exp_rd[c]) begin failures++; $display("FAIL alloc_rd_%0d actual=%h expected=%h", c, rd, exp_rd[c]); end
    end
    checks++; if (v !== 2'b11) begin failures++; $display("FAIL alloc_v3 actual=%b expected=11", v); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL alloc_busy3 actual=%b expected=0", busy); end
    re_ = 2'b00;
    step();
    checks++; if (v !== 2'b00) begin failures++; $display("FAIL alloc_v_empty actual=%b expected=00", v); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL alloc_busy_empty actual=%b expected=1", busy); end
  endtask

  task automatic test_ckpt_restore();
    do_reset();
    re_ = 2'b00; step();
    re_ = 2'b00; ckpt_ = 1'b0; step();
    checks++; if (ckpt_id !== 1'b1) begin failures++; $display("FAIL ckpt_id_after actual=%b expected=1", ckpt_id); end
    re_ = 2'b00; step();
    checks++; if (rd !== {3'd7, 3'd6}) begin failures++; $display("FAIL ckpt_pre_rstr_rd actual=%h expected=%h", rd, {3'd7, 3'd6}); end
    re_ = 2'b00; rstr_ = 1'b0; rstr_id = 1'b0; step();
    checks++; if (rd !== {3'd5, 3'd4}) begin failures++; $display("FAIL rstr_rd actual=%h expected=%h", rd, {3'd5, 3'd4}); end
    checks++; if (v !== 2'b11) begin failures++; $display("FAIL rstr_v actual=%b expected=11", v); end
    checks++; if (ckpt_id !== 1'b0) begin failures++; $display("FAIL rstr_ckpt_id actual=%b expected=0", ckpt_id); end
    checks++; if (ckpt_full !== 1'b0) begin failures++; $display("FAIL rstr_full actual=%b expected=0", ckpt_full); end
  endtask

  task automatic test_release_snap();
    // usage is 8'h0F here with no live checkpoint
    ckpt_ = 1'b0; step();
    we_ = 2'b10; wd = {3'd0, 3'd1}; step();
    checks++; if (rd !== {3'd4, 3'd1}) begin failures++; $display("FAIL rel_rd actual=%h expected=%h", rd, {3'd4, 3'd1}); end
    re_ = 2'b10; step();
    checks++; if (rd !== {3'd5, 3'd4}) begin failures++; $display("FAIL realloc_rd actual=%h expected=%h", rd, {3'd5, 3'd4}); end
    rstr_ = 1'b0; rstr_id = 1'b0; step();
    checks++; if (rd !== {3'd4, 3'd1}) begin failures++; $display("FAIL rel_rstr_rd actual=%h expected=%h", rd, {3'd4, 3'd1}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rel_rstr_busy actual=%b expected=0", busy); end
  endtask

  task automatic test_restore_release();
    // usage 8'h0D; rebuild snapshot 8'h0F
    re_ = 2'b10; step();
    ckpt_ = 1'b0; step();
    re_ = 2'b00; step();
    re_ = 2'b00; rstr_ = 1'b0; rstr_id = 1'b0; we_ = 2'b10; wd = {3'd0, 3'd2}; step();
    checks++; if (rd !== {3'd4, 3'd2}) begin failures++; $display("FAIL rstr_rel_rd actual=%h expected=%h", rd, {3'd4, 3'd2}); end
    checks++; if (v !== 2'b11) begin failures++; $display("FAIL rstr_rel_v actual=%b expected=11", v); end
    checks++; if (ckpt_id !== 1'b0) begin failures++; $display("FAIL rstr_rel_ckpt_id actual=%b expected=0", ckpt_id); end
  endtask

  task automatic test_ckpt_full();
    do_reset();
    ckpt_ = 1'b0; step();
    checks++; if (ckpt_id !== 1'b1) begin failures++; $display("FAIL full_id1 actual=%b expected=1", ckpt_id); end
    ckpt_ = 1'b0; step();
    checks++; if (ckpt_full !== 1'b1) begin failures++; $display("FAIL full_set actual=%b expected=1", ckpt_full); end
    checks++; if (ckpt_id !== 1'b0) begin failures++; $display("FAIL full_wrap_id actual=%b expected=0", ckpt_id); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL full_err_pre actual=%b expected=0", err); end
    ckpt_ = 1'b0; step();
    checks++; if (ckpt_full !== 1'b1) begin failures++; $display("FAIL full_ignored actual=%b expected=1", ckpt_full); end
    checks++; if (ckpt_id !== 1'b0) begin failures++; $display("FAIL full_ignored_id actual=%b expected=0", ckpt_id); end
    checks++; if (err !== EXP_ERR) begin failures++; $display("FAIL full_err actual=%b expected=%b", err, EXP_ERR); end
    cmt_ = 1'b0; step();
    checks++; if (ckpt_full !== 1'b0) begin failures++; $display("FAIL cmt_full actual=%b expected=0", ckpt_full); end
    ckpt_ = 1'b0; cmt_ = 1'b0; step();
    checks++; if (ckpt_full !== 1'b0) begin failures++; $display("FAIL both_full actual=%b expected=0", ckpt_full); end
    checks++; if (ckpt_id !== 1'b1) begin failures++; $display("FAIL both_id actual=%b expected=1", ckpt_id); end
    ckpt_ = 1'b0; step();
    checks++; if (ckpt_full !== 1'b1) begin failures++; $display("FAIL both_count actual=%b expected=1", ckpt_full); end
  endtask

  task automatic test_flush_reset();
    re_ = 2'b00; step();
    re_ = 2'b00; ckpt_ = 1'b0; flush_ = 1'b0; step();
    checks++; if (rd !== {3'd1, 3'd0}) begin failures++; $display("FAIL flush_rd actual=%h expected=%h", rd, {3'd1, 3'd0}); end
    checks++; if (ckpt_full !== 1'b0) begin failures++; $display("FAIL flush_full actual=%b expected=0", ckpt_full); end
    checks++; if (ckpt_id !== 1'b0) begin failures++; $display("FAIL flush_id actual=%b expected=0", ckpt_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy actual=%b expected=0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL flush_err actual=%b expected=0", err); end
    re_ = 2'b00; ckpt_ = 1'b0; step();
    checks++; if (rd !== {3'd3, 3'd2}) begin failures++; $display("FAIL pre_async_rd actual=%h expected=%h", rd, {3'd3, 3'd2}); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (rd !== {3'd1, 3'd0}) begin failures++; $display("FAIL async_rd actual=%h expected=%h", rd, {3'd1, 3'd0}); end
    checks++; if (ckpt_id !== 1'b0) begin failures++; $display("FAIL async_id actual=%b expected=0", ckpt_id); end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    idle();
    test_reset();
    test_alloc();
    test_ckpt_restore();
    test_release_snap();
    test_restore_release();
    test_ckpt_full();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
